// File: rtl/ov5640_data_capture.sv
// ============================================================================
// Module      : ov5640_data_capture
// Description : OV5640 byte capture; pairs RGB565 bytes, expands to RGB888 and
//               gates writes until the sensor has settled for PIC_WAIT frames.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ov5640_data_capture #(
  parameter int PIC_WAIT = 10,
  parameter int H_PIXEL  = 640,
  parameter int V_PIXEL  = 480
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        sys_init_done,
  input  logic        ov5640_vsync,
  input  logic        ov5640_href,
  input  logic [7:0]  ov5640_data,
  output logic        ov5640_wr_en,
  output logic [23:0] ov5640_data_out,
  output logic        pic_valid,
  output logic [3:0]  frame_cnt,
  output logic        line_err,
  output logic        frame_err
);

  logic        init_meta_q, init_s_q;
  logic        vsync_r_q, vsync_d_q, href_r_q, href_d_q;
  logic [7:0]  data_r_q, hi_byte_q, hi_byte_d;
  logic        byte_phase_q, byte_phase_d;
  logic [9:0]  pix_cnt_q, pix_cnt_d;
  logic [8:0]  line_cnt_q, line_cnt_d, line_cnt_end;
  logic [3:0]  frame_cnt_q, frame_cnt_d;
  logic        pic_valid_q, pic_valid_d;
  logic        wr_en_q, wr_en_d;
  logic [23:0] data_out_q, data_out_d;
  logic        line_err_q, line_err_d, frame_err_q, frame_err_d;

  logic        vs_rise, href_fall, pix_done;
  logic [15:0] pixel565;
  logic [23:0] pixel888;

  always_comb begin
    vs_rise   = vsync_r_q & ~vsync_d_q;
    href_fall = ~href_r_q & href_d_q;
    pix_done  = href_r_q & byte_phase_q;
    pixel565  = {hi_byte_q, data_r_q};
    pixel888  = {pixel565[15:11], pixel565[15:13],
                 pixel565[10:5],  pixel565[10:9],
                 pixel565[4:0],   pixel565[4:2]};

    frame_cnt_d = frame_cnt_q;
    pic_valid_d = pic_valid_q;
    if (!init_s_q) begin
      frame_cnt_d = 4'd0;
      pic_valid_d = 1'b0;
    end else if (vs_rise && (frame_cnt_q != 4'(PIC_WAIT))) begin
      frame_cnt_d = frame_cnt_q + 4'd1;
      if (frame_cnt_d == 4'(PIC_WAIT)) begin
        pic_valid_d = 1'b1;
      end
    end

    byte_phase_d = href_r_q ? ~byte_phase_q : 1'b0;
    hi_byte_d    = (href_r_q && !byte_phase_q) ? data_r_q : hi_byte_q;

    // Use the post-edge pic_valid so a dropped init stops writes one cycle sooner.
    wr_en_d    = pix_done & pic_valid_d;
    data_out_d = wr_en_d ? pixel888 : data_out_q;

    pix_cnt_d = pix_cnt_q;
    if (href_fall) begin
      pix_cnt_d = 10'd0;
    end else if (pix_done) begin
      pix_cnt_d = pix_cnt_q + 10'd1;
    end

    // A line ending on the same edge as vs_rise belongs to the finished frame.
    line_cnt_end = line_cnt_q + {8'd0, href_fall};
    line_cnt_d   = vs_rise ? 9'd0 : line_cnt_end;

    line_err_d  = line_err_q | (init_s_q & href_fall &
                  ((pix_cnt_q != 10'(H_PIXEL)) | byte_phase_q));
    frame_err_d = frame_err_q | (init_s_q & vs_rise & (frame_cnt_q != 4'd0) &
                  (line_cnt_end != 9'(V_PIXEL)));
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      init_meta_q  <= 1'b0;
      init_s_q     <= 1'b0;
      vsync_r_q    <= 1'b0;
      vsync_d_q    <= 1'b0;
      href_r_q     <= 1'b0;
      href_d_q     <= 1'b0;
      data_r_q     <= 8'd0;
      hi_byte_q    <= 8'd0;
      byte_phase_q <= 1'b0;
      pix_cnt_q    <= 10'd0;
      line_cnt_q   <= 9'd0;
      frame_cnt_q  <= 4'd0;
      pic_valid_q  <= 1'b0;
      wr_en_q      <= 1'b0;
      data_out_q   <= 24'd0;
      line_err_q   <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      init_meta_q  <= sys_init_done;
      init_s_q     <= init_meta_q;
      vsync_r_q    <= ov5640_vsync;
      vsync_d_q    <= vsync_r_q;
      href_r_q     <= ov5640_href;
      href_d_q     <= href_r_q;
      data_r_q     <= ov5640_data;
      hi_byte_q    <= hi_byte_d;
      byte_phase_q <= byte_phase_d;
      pix_cnt_q    <= pix_cnt_d;
      line_cnt_q   <= line_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      pic_valid_q  <= pic_valid_d;
      wr_en_q      <= wr_en_d;
      data_out_q   <= data_out_d;
      line_err_q   <= line_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign ov5640_wr_en    = wr_en_q;
  assign ov5640_data_out = data_out_q;
  assign pic_valid       = pic_valid_q;
  assign frame_cnt       = frame_cnt_q;
  assign line_err        = line_err_q;
  assign frame_err       = frame_err_q;

endmodule

`default_nettype wire

// File: tb/tb_ov5640_data_capture.sv
// ============================================================================
// Module      : tb_ov5640_data_capture
// Description : Self-checking bench for ov5640_data_capture (4x2 frames).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ov5640_data_capture;

  localparam int PW = 2;
  localparam int HP = 4;
  localparam int VP = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        init_done;
  logic        vsync, href;
  logic [7:0]  data;
  logic        wr_en;
  logic [23:0] data_out;
  logic        pic_valid;
  logic [3:0]  frame_cnt;
  logic        line_err, frame_err;

  ov5640_data_capture #(.PIC_WAIT(PW), .H_PIXEL(HP), .V_PIXEL(VP)) dut (
    .sys_clk         (clk),
    .sys_rst         (rst),
    .sys_init_done   (init_done),
    .ov5640_vsync    (vsync),
    .ov5640_href     (href),
    .ov5640_data     (data),
    .ov5640_wr_en    (wr_en),
    .ov5640_data_out (data_out),
    .pic_valid       (pic_valid),
    .frame_cnt       (frame_cnt),
    .line_err        (line_err),
    .frame_err       (frame_err)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Reference model state
  bit        m_init, m_pv, m_le, m_fe;
  int        m_fc, m_lines;
  logic [23:0] exp_q[$];
  logic [23:0] obs_q[$];
  logic [7:0]  lb[$];
  bit          mon_en = 1'b1;

  always @(negedge clk) begin
    if (mon_en && wr_en === 1'b1) obs_q.push_back(data_out);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [23:0] rgb888(input logic [15:0] p);
    int r5, g6, b5;
    r5 = int'(p) / 2048;
    g6 = (int'(p) / 32) % 64;
    b5 = int'(p) % 32;
    return {8'(r5 * 8 + r5 / 4), 8'(g6 * 4 + g6 / 16), 8'(b5 * 8 + b5 / 4)};
  endfunction

  task automatic cyc(input logic v, input logic h, input logic [7:0] d);
    @(negedge clk);
    vsync = v; href = h; data = d;
  endtask

  task automatic fill(input int n);
    lb.delete();
    for (int i = 0; i < n; i++) lb.push_back(8'($urandom));
  endtask

  task automatic send_line();
    for (int i = 0; i < lb.size(); i++) begin
      cyc(1'b0, 1'b1, lb[i]);
      if ((i % 2 == 1) && m_pv) exp_q.push_back(rgb888({lb[i-1], lb[i]}));
    end
    repeat (3) cyc(1'b0, 1'b0, 8'h00);
    m_lines++;
    if (m_init && lb.size() != 2 * HP) m_le = 1'b1;
  endtask

  task automatic good_lines(input int n);
    for (int k = 0; k < n; k++) begin
      fill(2 * HP);
      send_line();
    end
  endtask

  task automatic send_vsync();
    repeat (3) cyc(1'b1, 1'b0, 8'h00);
    repeat (3) cyc(1'b0, 1'b0, 8'h00);
    if (m_init) begin
      if (m_fc > 0 && m_lines != VP) m_fe = 1'b1;
      if (m_fc < PW) m_fc++;
      if (m_fc == PW) m_pv = 1'b1;
    end
    m_lines = 0;
  endtask

  task automatic model_reset();
    m_init = 0; m_pv = 0; m_le = 0; m_fe = 0; m_fc = 0; m_lines = 0;
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; init_done = 1'b0; vsync = 1'b0; href = 1'b0; data = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    n_total++;
    if ({wr_en, data_out, pic_valid, frame_cnt, line_err, frame_err} !== 32'd0)
      $display("FAIL reset_outputs: got %h expected 0",
               {wr_en, data_out, pic_valid, frame_cnt, line_err, frame_err});
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_settle();
    init_done = 1'b1;
    repeat (4) cyc(1'b0, 1'b0, 8'h00);
    m_init = 1'b1;
    good_lines(1);
    send_vsync();
    n_total++;
    if (frame_cnt !== 4'(m_fc) || pic_valid !== m_pv || frame_err !== m_fe)
      $display("FAIL settle_vs1: got cnt=%0d pv=%b ferr=%b expected cnt=%0d pv=%b ferr=%b",
               frame_cnt, pic_valid, frame_err, m_fc, m_pv, m_fe);
    else n_pass++;
    good_lines(VP);
    send_vsync();
    n_total++;
    if (frame_cnt !== 4'(m_fc) || pic_valid !== m_pv)
      $display("FAIL settle_vs2: got cnt=%0d pv=%b expected cnt=%0d pv=%b",
               frame_cnt, pic_valid, m_fc, m_pv);
    else n_pass++;
    n_total++;
    if (obs_q.size() != 0) $display("FAIL settle_early_wr: got %0d writes expected 0", obs_q.size());
    else n_pass++;
    good_lines(VP);
    send_vsync();
    n_total++;
    if (frame_cnt !== 4'(m_fc) || line_err !== m_le || frame_err !== m_fe)
      $display("FAIL settle_vs3: got cnt=%0d lerr=%b ferr=%b expected cnt=%0d lerr=%b ferr=%b",
               frame_cnt, line_err, frame_err, m_fc, m_le, m_fe);
    else n_pass++;
    n_total++;
    if (obs_q.size() != exp_q.size())
      $display("FAIL settle_wr_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_total++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL settle_pixel[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
      else n_pass++;
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_colors();
    logic [7:0]  b[8];
    logic [23:0] col[4];
    logic        exp_wr;
    b[0] = 8'hF8; b[1] = 8'h00; b[2] = 8'h07; b[3] = 8'hE0;
    b[4] = 8'h00; b[5] = 8'h1F; b[6] = 8'($urandom); b[7] = 8'($urandom);
    col[0] = 24'hFF0000; col[1] = 24'h00FF00; col[2] = 24'h0000FF;
    col[3] = rgb888({b[6], b[7]});
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      // second byte driven at c-2 shows as a write at c
      exp_wr = m_pv && (c >= 3) && ((c - 3) % 2 == 0);
      n_total++;
      if (wr_en !== exp_wr) $display("FAIL colors_wr_en[c%0d]: got %b expected %b", c, wr_en, exp_wr);
      else n_pass++;
      if (exp_wr) begin
        n_total++;
        if (data_out !== col[(c - 3) / 2])
          $display("FAIL colors_data[c%0d]: got %h expected %h", c, data_out, col[(c - 3) / 2]);
        else n_pass++;
      end
      vsync = 1'b0;
      if (c < 8) begin href = 1'b1; data = b[c]; end
      else begin href = 1'b0; data = 8'h00; end
    end
    repeat (2) cyc(1'b0, 1'b0, 8'h00);
    m_lines++;
    good_lines(VP - 1);
    send_vsync();
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_orphan();
    fill(2 * HP - 1);
    send_line();
    n_total++;
    if (line_err !== m_le) $display("FAIL orphan_line_err: got %b expected %b", line_err, m_le);
    else n_pass++;
    good_lines(VP - 1);
    send_vsync();
    good_lines(VP);
    send_vsync();
    n_total++;
    if (line_err !== m_le || frame_err !== m_fe)
      $display("FAIL orphan_sticky: got lerr=%b ferr=%b expected lerr=%b ferr=%b",
               line_err, frame_err, m_le, m_fe);
    else n_pass++;
    n_total++;
    if (obs_q.size() != exp_q.size())
      $display("FAIL orphan_wr_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_total++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL orphan_pixel[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
      else n_pass++;
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_frame_err();
    good_lines(VP + 1);
    n_total++;
    if (frame_err !== m_fe) $display("FAIL frame_err_before: got %b expected %b", frame_err, m_fe);
    else n_pass++;
    send_vsync();
    n_total++;
    if (frame_err !== m_fe) $display("FAIL frame_err_after: got %b expected %b", frame_err, m_fe);
    else n_pass++;
    n_total++;
    if (obs_q.size() != exp_q.size())
      $display("FAIL frame_err_wr_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_total++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL frame_err_pixel[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
      else n_pass++;
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_init_drop();
    mon_en = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c >= 6) begin
        n_total++;
        if (wr_en !== 1'b0) $display("FAIL init_drop_wr_en[c%0d]: got %b expected 0", c, wr_en);
        else n_pass++;
      end
      vsync = 1'b0;
      if (c < 8) begin href = 1'b1; data = 8'($urandom); end
      else begin href = 1'b0; data = 8'h00; end
      if (c == 3) init_done = 1'b0;
    end
    m_init = 0; m_fc = 0; m_pv = 0; m_lines++;
    n_total++;
    if (frame_cnt !== 4'(m_fc) || pic_valid !== m_pv)
      $display("FAIL init_drop_clear: got cnt=%0d pv=%b expected cnt=%0d pv=%b",
               frame_cnt, pic_valid, m_fc, m_pv);
    else n_pass++;
    good_lines(1);
    obs_q.delete(); exp_q.delete();
    mon_en = 1'b1;
    init_done = 1'b1;
    repeat (4) cyc(1'b0, 1'b0, 8'h00);
    m_init = 1'b1;
    send_vsync();
    good_lines(VP);
    send_vsync();
    n_total++;
    if (frame_cnt !== 4'(m_fc) || pic_valid !== m_pv || obs_q.size() != 0)
      $display("FAIL init_resettle: got cnt=%0d pv=%b wr=%0d expected cnt=%0d pv=%b wr=0",
               frame_cnt, pic_valid, obs_q.size(), m_fc, m_pv);
    else n_pass++;
    good_lines(VP);
    send_vsync();
    n_total++;
    if (obs_q.size() != exp_q.size() || frame_err !== m_fe)
      $display("FAIL init_rewrite: got wr=%0d ferr=%b expected wr=%0d ferr=%b",
               obs_q.size(), frame_err, exp_q.size(), m_fe);
    else n_pass++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_total++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL init_pixel[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
      else n_pass++;
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_async_reset();
    repeat (3) cyc(1'b0, 1'b1, 8'($urandom));
    #2 rst = 1'b1;
    #1;
    n_total++;
    if ({wr_en, data_out, pic_valid, frame_cnt, line_err, frame_err} !== 32'd0)
      $display("FAIL async_reset_outputs: got %h expected 0",
               {wr_en, data_out, pic_valid, frame_cnt, line_err, frame_err});
    else n_pass++;
    repeat (3) cyc(1'b0, 1'b1, 8'($urandom));
    repeat (2) cyc(1'b0, 1'b0, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (4) cyc(1'b0, 1'b0, 8'h00);
    m_init = 1'b1;
    good_lines(1);
    n_total++;
    if (line_err !== m_le) $display("FAIL post_reset_pairing: got lerr=%b expected %b", line_err, m_le);
    else n_pass++;
    send_vsync();
    good_lines(VP);
    send_vsync();
    good_lines(VP);
    send_vsync();
    n_total++;
    if (obs_q.size() != exp_q.size() || line_err !== m_le || frame_err !== m_fe || frame_cnt !== 4'(m_fc))
      $display("FAIL post_reset_frame: got wr=%0d lerr=%b ferr=%b cnt=%0d expected wr=%0d lerr=%b ferr=%b cnt=%0d",
               obs_q.size(), line_err, frame_err, frame_cnt, exp_q.size(), m_le, m_fe, m_fc);
    else n_pass++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_total++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL post_reset_pixel[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
      else n_pass++;
    end
    obs_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_settle();
    test_colors();
    test_orphan();
    test_frame_err();
    test_init_drop();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
